rle_decompressor: RTL

//  Expands an 8-bit run-length stream of (pixel, count) pairs back into a raw
//  8-bit pixel stream. It is the decode-side counterpart of the RLE compressor
//  and sits between the compressed-image buffer/link and the pixel sink (frame

---
 rtl/rle_decompressor.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/rle_decompressor.sv
// rle_decompressor: expands (pixel, count) run-length pairs into a raw 8-bit pixel stream.
// Latency: a pair accepted in cycle N gives its first pixel in cycle N+1. A run of L takes L cycles, plus one fetch cycle between runs.
// Backpressure: ready_out is high only while fetching a pair. pixel_valid and pixel_out hold steady until pixel_ready.
//
// Ports:
//   clk, rst                     clock (rising edge), asynchronous active-high reset
//   start                        one-cycle pulse that arms a new frame; honoured only in IDLE
//   data_in/count_in/last_in     run pixel, run length and end-of-frame marker
//   valid_in/ready_out           pair handshake
//   pixel_out/pixel_valid/pixel_ready   expanded pixel stream handshake
//   done                         one-cycle end-of-frame pulse
//   pixel_count/pair_count       per-frame statistics; they hold until the next start
//   err                          sticky error flag
// Optional feature macro: RLE_DEC_ERR_CHECK_EN enables err.
//   err is set by a zero-count pair, by a run overrun, or by a last_in frame that is short.
//   When the macro is absent, err is tied low.
module rle_decompressor #(
  parameter int MAX_PIXELS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  data_in,
  input  logic [7:0]  count_in,
  input  logic        last_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [7:0]  pixel_out,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        done,
  output logic [15:0] pixel_count,
  output logic [15:0] pair_count,
  output logic        err
);

  localparam logic [15:0] MAX16 = 16'(MAX_PIXELS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_EMIT   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_pixel;
  logic [7:0]  r_remaining;
  logic        r_last;
  logic [15:0] r_pixel_count;
  logic [15:0] r_pair_count;

  logic        w_accept;
  logic        w_xfer;
  logic [15:0] w_pc_inc;
  logic        w_hit_max;
  logic        w_run_end;

  assign w_accept  = (r_state == S_FETCH) & valid_in;
  assign w_xfer    = (r_state == S_EMIT) & pixel_ready;
  assign w_pc_inc  = r_pixel_count + 16'd1;
  // The beat now transferring is the last pixel this frame may carry.
  assign w_hit_max = (w_pc_inc == MAX16);
  // The beat now transferring is the final pixel of the current run.
  assign w_run_end = (r_remaining == 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    ready_out   = 1'b0;
    pixel_valid = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        ready_out = 1'b1;
        if (w_accept) begin
          if (count_in != 8'd0) w_next = S_EMIT;
          else if (last_in)     w_next = S_FINISH;
        end
      end
      S_EMIT: begin
        pixel_valid = 1'b1;
        // Reaching MAX_PIXELS ends the frame even mid-run; the rest of the run is dropped.
        if (w_xfer) begin
          if (w_hit_max || (w_run_end && r_last)) w_next = S_FINISH;
          else if (w_run_end)                     w_next = S_FETCH;
        end
      end
      S_FINISH: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pixel       <= 8'd0;
      r_remaining   <= 8'd0;
      r_last        <= 1'b0;
      r_pixel_count <= 16'd0;
      r_pair_count  <= 16'd0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_pixel_count <= 16'd0;
        r_pair_count  <= 16'd0;
      end
      if (w_accept) begin
        r_pixel      <= data_in;
        r_remaining  <= count_in;
        r_last       <= last_in;
        r_pair_count <= r_pair_count + 16'd1;
      end
      if (w_xfer) begin
        r_remaining   <= r_remaining - 8'd1;
        r_pixel_count <= w_pc_inc;
      end
    end
  end

  assign pixel_out   = r_pixel;
  assign pixel_count = r_pixel_count;
  assign pair_count  = r_pair_count;

`ifdef RLE_DEC_ERR_CHECK_EN
  logic r_err;
  logic w_err_set;

  // Error sources, in order:
  //   1. a zero-count pair;
  //   2. MAX_PIXELS is reached while the run still has pixels left;
  //   3. a run flagged last ends before MAX_PIXELS.
  // A zero-count last pair is already covered by source 1.
  assign w_err_set = (w_accept && (count_in == 8'd0))
                   | (w_xfer && w_hit_max && !w_run_end)
                   | (w_xfer && w_run_end && r_last && !w_hit_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
